// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolver, predictor update port and branch counters
module branch_resolve_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              validD_i,
    input  logic              stallD_i,
    input  logic              flushD_i,
    input  logic [3:0]        br_typeD_i,
    input  logic [ADDR_W-1:0] pcD_i,
    input  logic [ADDR_W-1:0] offsD_i,
    input  logic [ADDR_W-1:0] rjD_i,
    input  logic [ADDR_W-1:0] rdD_i,
    input  logic              pred_takenD_i,
    input  logic [ADDR_W-1:0] pred_targetD_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              upd_branch_o,
    output logic              upd_error_o,
    output logic              upd_taken_o,
    output logic [ADDR_W-1:0] upd_src_pc_o,
    output logic [ADDR_W-1:0] upd_tgt_pc_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  mis_cnt_o
);

    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_BEQZ = 4'd7;
    localparam logic [3:0] BR_BNEZ = 4'd8;
    localparam logic [3:0] BR_B    = 4'd9;
    localparam logic [3:0] BR_BL   = 4'd10;
    localparam logic [3:0] BR_JIRL = 4'd11;

    logic              kill_q, kill_d;
    logic              is_br, cond, taken, err, fire;
    logic [ADDR_W-1:0] tgt, seq_pc;
    logic              upd_branch_q, upd_error_q, upd_taken_q;
    logic [ADDR_W-1:0] upd_src_pc_q, upd_tgt_pc_q;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    always_comb begin
        cond = 1'b0;
        case (br_typeD_i)
            BR_BEQ:  cond = (rjD_i == rdD_i);
            BR_BNE:  cond = (rjD_i != rdD_i);
            BR_BLT:  cond = ($signed(rjD_i) < $signed(rdD_i));
            BR_BGE:  cond = ($signed(rjD_i) >= $signed(rdD_i));
            BR_BLTU: cond = (rjD_i < rdD_i);
            BR_BGEU: cond = (rjD_i >= rdD_i);
            BR_BEQZ: cond = (rjD_i == '0);
            BR_BNEZ: cond = (rjD_i != '0);
            BR_B, BR_BL, BR_JIRL: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign is_br  = (br_typeD_i >= BR_BEQ) && (br_typeD_i <= BR_JIRL);
    assign taken  = is_br & cond;
    assign tgt    = ((br_typeD_i == BR_JIRL) ? rjD_i : pcD_i) + offsD_i;
    assign seq_pc = pcD_i + ADDR_W'(4);
    // A predicted-taken non-branch is an aliased BTB hit and must be undone too.
    assign err    = is_br ? ((taken != pred_takenD_i) | (taken & (pred_targetD_i != tgt)))
                          : pred_takenD_i;
    assign fire   = validD_i & ~stallD_i & ~flushD_i & ~kill_q;

    assign redirect_o    = fire & err;
    assign redirect_pc_o = (fire & taken) ? tgt : seq_pc;
    assign kill_d        = redirect_o;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (cnt_clr_i) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (fire & is_br & (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
            if (fire & err & (mis_cnt_q != '1))  mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kill_q       <= 1'b0;
            upd_branch_q <= 1'b0;
            upd_error_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_src_pc_q <= '0;
            upd_tgt_pc_q <= '0;
            br_cnt_q     <= '0;
            mis_cnt_q    <= '0;
        end else begin
            kill_q       <= kill_d;
            upd_branch_q <= fire & is_br;
            upd_error_q  <= fire & err;
            upd_taken_q  <= fire & taken;
            upd_src_pc_q <= pcD_i;
            upd_tgt_pc_q <= tgt;
            br_cnt_q     <= br_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign upd_branch_o = upd_branch_q;
    assign upd_error_o  = upd_error_q;
    assign upd_taken_o  = upd_taken_q;
    assign upd_src_pc_o = upd_src_pc_q;
    assign upd_tgt_pc_o = upd_tgt_pc_q;
    assign br_cnt_o     = br_cnt_q;
    assign mis_cnt_o    = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed bench with a reference model for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, pt = 1'b0, clr = 1'b0;
    logic [3:0]  typ = 4'd0;
    logic [31:0] pc = 32'h0, offs = 32'h0, rj = 32'h0, rd = 32'h0, ptg = 32'h0;

    logic        redirect, upd_branch, upd_error, upd_taken;
    logic [31:0] redirect_pc, upd_src_pc, upd_tgt_pc, br_cnt, mis_cnt;
    logic        s_redirect, s_upd_branch, s_upd_error, s_upd_taken;
    logic [31:0] s_redirect_pc, s_upd_src_pc, s_upd_tgt_pc;
    logic [2:0]  s_br_cnt, s_mis_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .validD_i(valid), .stallD_i(stall), .flushD_i(flush),
        .br_typeD_i(typ), .pcD_i(pc), .offsD_i(offs), .rjD_i(rj), .rdD_i(rd),
        .pred_takenD_i(pt), .pred_targetD_i(ptg),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc),
        .upd_branch_o(upd_branch), .upd_error_o(upd_error), .upd_taken_o(upd_taken),
        .upd_src_pc_o(upd_src_pc), .upd_tgt_pc_o(upd_tgt_pc),
        .cnt_clr_i(clr), .br_cnt_o(br_cnt), .mis_cnt_o(mis_cnt)
    );

    branch_resolve_unit #(.ADDR_W(32), .CNT_W(3)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .validD_i(valid), .stallD_i(stall), .flushD_i(flush),
        .br_typeD_i(typ), .pcD_i(pc), .offsD_i(offs), .rjD_i(rj), .rdD_i(rd),
        .pred_takenD_i(pt), .pred_targetD_i(ptg),
        .redirect_o(s_redirect), .redirect_pc_o(s_redirect_pc),
        .upd_branch_o(s_upd_branch), .upd_error_o(s_upd_error), .upd_taken_o(s_upd_taken),
        .upd_src_pc_o(s_upd_src_pc), .upd_tgt_pc_o(s_upd_tgt_pc),
        .cnt_clr_i(clr), .br_cnt_o(s_br_cnt), .mis_cnt_o(s_mis_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state that the spec says survives a clock edge.
    bit      m_kill = 0;
    bit      m_br = 0, m_err = 0, m_tk = 0;
    int      m_src = 0, m_tgt = 0;
    longint  m_brc = 0, m_misc = 0, m_sbrc = 0, m_smisc = 0;

    function automatic void resolve(output bit isbr, output bit tk, output bit e, output logic [31:0] tg);
        bit c;
        isbr = (typ >= 1) && (typ <= 11);
        case (typ)
            1: c = rj == rd;
            2: c = rj != rd;
            3: c = $signed(rj) < $signed(rd);
            4: c = !($signed(rj) < $signed(rd));
            5: c = rj < rd;
            6: c = !(rj < rd);
            7: c = rj == 0;
            8: c = rj != 0;
            9, 10, 11: c = 1;
            default: c = 0;
        endcase
        tk = isbr && c;
        tg = (typ == 11) ? rj + offs : pc + offs;
        if (isbr) e = (tk != pt) || (tk && ptg != tg);
        else      e = pt;
    endfunction

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    always @(negedge clk) begin
        bit isbr, tk, e, fire;
        logic [31:0] tg;
        if (!rst_n) begin
            m_kill = 0; m_br = 0; m_err = 0; m_tk = 0; m_src = 0; m_tgt = 0;
            m_brc = 0; m_misc = 0; m_sbrc = 0; m_smisc = 0;
        end
        resolve(isbr, tk, e, tg);
        fire = valid && !stall && !flush && !m_kill;
        chk("redirect", {31'b0, redirect}, {31'b0, fire && e});
        chk("redirect_pc", redirect_pc, (fire && tk) ? tg : pc + 32'd4);
        chk("upd_branch", {31'b0, upd_branch}, {31'b0, m_br});
        chk("upd_error", {31'b0, upd_error}, {31'b0, m_err});
        chk("upd_taken", {31'b0, upd_taken}, {31'b0, m_tk});
        chk("upd_src_pc", upd_src_pc, m_src);
        chk("upd_tgt_pc", upd_tgt_pc, m_tgt);
        chk("br_cnt", br_cnt, m_brc[31:0]);
        chk("mis_cnt", mis_cnt, m_misc[31:0]);
        chk("small_br_cnt", {29'b0, s_br_cnt}, m_sbrc[31:0]);
        chk("small_mis_cnt", {29'b0, s_mis_cnt}, m_smisc[31:0]);
        if (rst_n) begin
            m_kill = fire && e;
            m_br = fire && isbr; m_err = fire && e; m_tk = fire && tk;
            m_src = pc; m_tgt = tg;
            if (clr) begin
                m_brc = 0; m_misc = 0; m_sbrc = 0; m_smisc = 0;
            end else begin
                if (fire && isbr) begin
                    m_brc = sat_inc(m_brc, 64'hFFFF_FFFF); m_sbrc = sat_inc(m_sbrc, 7);
                end
                if (fire && e) begin
                    m_misc = sat_inc(m_misc, 64'hFFFF_FFFF); m_smisc = sat_inc(m_smisc, 7);
                end
            end
        end
    end

    task automatic step(input logic [3:0] t, input logic [31:0] p, input logic [31:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic prt,
                        input logic [31:0] prg, input logic v = 1'b1, input logic s = 1'b0,
                        input logic f = 1'b0);
        @(posedge clk); #1;
        typ = t; pc = p; offs = o; rj = a; rd = b; pt = prt; ptg = prg;
        valid = v; stall = s; flush = f;
        #2;
    endtask

    task automatic idle();
        step(4'd0, 32'h1C00_0F00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        idle(); idle();
        chk("rst_upd_branch", {31'b0, upd_branch}, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // BEQ predicted correctly
        step(4'd1, 32'h1C00_0010, 32'h40, 32'd5, 32'd5, 1'b1, 32'h1C00_0050);
        chk("beq_redirect", {31'b0, redirect}, 32'd0);
        idle();
        chk("beq_upd_branch", {31'b0, upd_branch}, 32'd1);
        chk("beq_upd_error", {31'b0, upd_error}, 32'd0);
        chk("beq_upd_taken", {31'b0, upd_taken}, 32'd1);
        chk("beq_upd_tgt", upd_tgt_pc, 32'h1C00_0050);
        chk("beq_br_cnt", br_cnt, 32'd1);

        // BLT direction mispredict, then a would-be mispredicting branch on the wrong path
        step(4'd3, 32'h1C00_0100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        chk("blt_redirect", {31'b0, redirect}, 32'd1);
        chk("blt_redirect_pc", redirect_pc, 32'h1C00_0120);
        step(4'd1, 32'h1C00_0124, 32'h40, 32'd7, 32'd7, 1'b0, 32'h0);
        chk("blt_upd_error", {31'b0, upd_error}, 32'd1);
        chk("blt_mis_cnt", mis_cnt, 32'd1);
        chk("killed_redirect", {31'b0, redirect}, 32'd0);
        idle();
        chk("killed_upd_branch", {31'b0, upd_branch}, 32'd0);
        chk("killed_br_cnt", br_cnt, 32'd2);

        // BLTU with the same operands is not taken
        step(4'd5, 32'h1C00_0200, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h1C00_0220);
        chk("bltu_redirect_pc", redirect_pc, 32'h1C00_0204);
        idle();
        chk("bltu_upd_taken", {31'b0, upd_taken}, 32'd0);
        chk("bltu_upd_error", {31'b0, upd_error}, 32'd1);

        // JIRL target mispredict
        step(4'd11, 32'h1C00_0300, 32'h8, 32'h1C00_1000, 32'h0, 1'b1, 32'h1C00_0000);
        chk("jirl_redirect_pc", redirect_pc, 32'h1C00_1008);
        idle();
        chk("jirl_upd_error", {31'b0, upd_error}, 32'd1);
        chk("jirl_upd_tgt", upd_tgt_pc, 32'h1C00_1008);

        // BNE held three cycles by stall
        repeat (3) step(4'd2, 32'h1C00_0500, 32'h10, 32'd1, 32'd2, 1'b1, 32'h1C00_0510, 1'b1, 1'b1);
        chk("stall_upd_branch", {31'b0, upd_branch}, 32'd0);
        step(4'd2, 32'h1C00_0500, 32'h10, 32'd1, 32'd2, 1'b1, 32'h1C00_0510);
        chk("stall_release_upd", {31'b0, upd_branch}, 32'd0);
        idle();
        chk("stall_upd_once", {31'b0, upd_branch}, 32'd1);
        idle();
        chk("stall_upd_held1", {31'b0, upd_branch}, 32'd0);

        // flushed mispredicting branch
        step(4'd1, 32'h1C00_0600, 32'h10, 32'd3, 32'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("flush_redirect", {31'b0, redirect}, 32'd0);
        idle();
        chk("flush_upd_branch", {31'b0, upd_branch}, 32'd0);

        // aliased BTB hit on a non-branch, and out-of-range types
        step(4'd0, 32'h1C00_0400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
        chk("alias_redirect", {31'b0, redirect}, 32'd1);
        chk("alias_redirect_pc", redirect_pc, 32'h1C00_0404);
        idle();
        chk("alias_upd_branch", {31'b0, upd_branch}, 32'd0);
        chk("alias_upd_error", {31'b0, upd_error}, 32'd1);
        step(4'd13, 32'h1C00_0410, 32'h40, 32'd0, 32'd0, 1'b0, 32'h0);
        step(4'd15, 32'h1C00_0420, 32'h40, 32'd0, 32'd0, 1'b1, 32'h1C00_0460);
        idle();

        // flush and kill together suppress one instruction only
        step(4'd0, 32'h1C00_0700, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(4'd1, 32'h1C00_0704, 32'h10, 32'd1, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(4'd1, 32'h1C00_0800, 32'h10, 32'd1, 32'd1, 1'b1, 32'h1C00_0810);
        chk("after_kill_redirect", {31'b0, redirect}, 32'd0);
        idle();
        chk("after_kill_upd", {31'b0, upd_branch}, 32'd1);

        // remaining compare kinds and address wrap, checked by the model
        step(4'd4, 32'h1C00_0900, 32'h10, 32'h8000_0000, 32'd1, 1'b0, 32'h0);
        idle();
        step(4'd6, 32'h1C00_0A00, 32'h10, 32'h8000_0000, 32'd1, 1'b1, 32'h1C00_0A10);
        step(4'd7, 32'h1C00_0B00, 32'hFFFF_FFF0, 32'd0, 32'd9, 1'b1, 32'h1C00_0AF0);
        step(4'd8, 32'h1C00_0C00, 32'h20, 32'd0, 32'd0, 1'b1, 32'h1C00_0C20);
        idle();
        step(4'd10, 32'h1C00_0D00, 32'h100, 32'd0, 32'd0, 1'b1, 32'h1C00_0E00);
        step(4'd9, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 1'b1, 32'h0000_0010);
        step(4'd7, 32'hFFFF_FFFC, 32'h20, 32'd1, 32'd0, 1'b0, 32'h0);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);

        // saturation in the 3-bit build
        repeat (10) step(4'd9, 32'h1C00_1000, 32'h10, 32'd0, 32'd0, 1'b1, 32'h1C00_1010);
        repeat (8) begin
            step(4'd0, 32'h1C00_1100, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
            idle();
        end
        idle();
        chk("small_br_sat", {29'b0, s_br_cnt}, 32'd7);
        chk("small_mis_sat", {29'b0, s_mis_cnt}, 32'd7);

        // clear wins over a same-cycle mispredicting branch
        step(4'd1, 32'h1C00_1200, 32'h10, 32'd1, 32'd2, 1'b1, 32'h1C00_1210);
        clr = 1'b1;
        idle();
        clr = 1'b0;
        chk("clr_br_cnt", br_cnt, 32'd0);
        chk("clr_mis_cnt", mis_cnt, 32'd0);
        chk("clr_small_br", {29'b0, s_br_cnt}, 32'd0);
        chk("clr_upd_error", {31'b0, upd_error}, 32'd1);

        // reset in the middle of a firing cycle drops its update
        step(4'd1, 32'h1C00_1300, 32'h10, 32'd4, 32'd4, 1'b1, 32'h1C00_1310);
        rst_n = 1'b0;
        idle();
        chk("rst_mid_upd", {31'b0, upd_branch}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle();
        chk("rst_after_upd", {31'b0, upd_branch}, 32'd0);
        chk("rst_after_br_cnt", br_cnt, 32'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
